// File: rtl/table_flush_sequencer.sv
// table_flush_sequencer
// Erases the flow table after a watchdog flush strobe. It waits for the lookup
// pipeline to drain, then writes an all-zero (invalid) entry to every address,
// and finally pulses flush_done. Strobes that arrive while an erase is running
// collapse into a single pending follow-up erase.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no erase in progress, table write port released
// DRAIN | erase requested, stalling lookups until the pipeline is empty
// WRITE | writing a zero entry at addr_cnt, advancing on each wr_ack
// DONE  | last entry written, flush_done pulse, start follow-up if pending
module table_flush_sequencer #(
    parameter int TABLE_DEPTH = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int ENTRY_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   table_flush,
    input  logic                   lookup_idle,
    output logic                   flush_busy,
    output logic                   wr_req,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [ENTRY_WIDTH-1:0] wr_data,
    input  logic                   wr_ack,
    output logic                   flush_done,
    output logic [15:0]            flush_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic                  pending;
    logic                  pending_next;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  busy_d;
    logic                  req_d;
    logic                  done_d;

    // The written entry is always the invalid (all-zero) pattern.
    assign wr_data = '0;
    assign wr_addr = addr_cnt;

    // State, pending flag, address counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            addr_cnt    <= '0;
            flush_busy  <= 1'b0;
            wr_req      <= 1'b0;
            flush_done  <= 1'b0;
            flush_count <= 16'h0000;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            addr_cnt   <= addr_next;
            flush_busy <= busy_d;
            wr_req     <= req_d;
            flush_done <= done_d;
            // Count is bumped on entry to DONE so it moves together with flush_done.
            if (state_next == DONE) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

    // Next-state, pending coalescing and address advance.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        addr_next    = addr_cnt;
        case (state)
            IDLE: begin
                if (table_flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (table_flush) begin
                    pending_next = 1'b1;
                end
                if (lookup_idle) begin
                    state_next = WRITE;
                    addr_next  = '0;
                end
            end
            WRITE: begin
                if (table_flush) begin
                    pending_next = 1'b1;
                end
                if (wr_ack) begin
                    if (addr_cnt == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        addr_next = addr_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                // A strobe landing in DONE is folded straight into the follow-up.
                if (pending || table_flush) begin
                    state_next   = DRAIN;
                    pending_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, captured by the state register.
    always_comb begin
        busy_d = (state_next != IDLE);
        req_d  = (state_next == WRITE);
        done_d = (state_next == DONE);
    end

endmodule

// File: doc/table_flush_sequencer.md
# table_flush_sequencer

Consumes the one-cycle `table_flush` strobe produced by the watchdog timer and erases the flow table by writing an invalid (all-zero) entry to every address. It sits between the watchdog and the table's write port. It stalls the lookup pipeline while erasing, then reports completion. Flush requests that arrive during an erase are coalesced into exactly one follow-up erase.

## Interface
Parameters:
- `TABLE_DEPTH`, default 32: number of table entries to erase, addresses 0..TABLE_DEPTH-1; any value ≥ 2, power of two not required.
- `ADDR_WIDTH`, default 5: width of `wr_addr`; 2^ADDR_WIDTH ≥ TABLE_DEPTH.
- `ENTRY_WIDTH`, default 256: width of one table entry; bit 0 is the valid bit.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `table_flush`  in  1  flush request strobe from watchdog; sampled every cycle.
- `lookup_idle`  in  1  lookup pipeline has no transaction in flight.
- `flush_busy`  out  1  stall lookups / other table writers while high.
- `wr_req`  out  1  table write request.
- `wr_addr`  out  ADDR_WIDTH  table write address.
- `wr_data`  out  ENTRY_WIDTH  table write data; constant zero (valid bit clear).
- `wr_ack`  in  1  table accepted the write in this cycle (valid only with `wr_req`).
- `flush_done`  out  1  one-cycle pulse at end of each erase.
- `flush_count`  out  16  number of completed erases, wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, DRAIN, WRITE, DONE.
- IDLE: `flush_busy`=0, `wr_req`=0. `table_flush`=1 → DRAIN.
- DRAIN: `flush_busy`=1. `lookup_idle`=1 → WRITE with address counter = 0; otherwise stay in DRAIN indefinitely.
- WRITE: `flush_busy`=1, `wr_req`=1, `wr_addr`=counter.
  - `wr_req`, `wr_addr` and `wr_data` stay stable until `wr_ack`.
  - `wr_ack` with counter < TABLE_DEPTH-1 → counter+1; `wr_req` stays high.
  - `wr_ack` with counter = TABLE_DEPTH-1 → DONE.
- DONE: `flush_busy`=1, `wr_req`=0, `flush_done`=1, `flush_count`+1.
  - Pending flag set → clear it, go to DRAIN.
  - Otherwise → IDLE.
- Pending flag:
  - Set by `table_flush`=1 in DRAIN, WRITE or DONE.
  - Single bit, so any number of strobes during an erase yields exactly one follow-up erase.
  - `table_flush` in DONE sets pending and causes the follow-up.
- The in-progress erase is never restarted; it always runs to completion.
- `wr_ack` while `wr_req`=0 is ignored.
- `wr_data` is tied to zero in every state.

## Timing
- Reset values: state IDLE, `flush_busy`=0, `wr_req`=0, `wr_addr`=0, `flush_done`=0, `flush_count`=0, pending=0, counter=0.
- Reset asserted mid-erase → next cycle is IDLE with all reset values; pending is discarded and the partial erase is not resumed.
- All outputs are registered.
- Latencies with `table_flush` at cycle N, `lookup_idle`=1 and `wr_ack`=1 every cycle:
  - DRAIN at N+1; `flush_busy`=1 from N+1.
  - WRITE from N+2 to N+1+TABLE_DEPTH, one address per cycle.
  - `flush_done`=1 at N+2+TABLE_DEPTH.
  - IDLE at N+3+TABLE_DEPTH, `flush_busy`=0.
- Each cycle `lookup_idle`=0 in DRAIN adds one cycle.
- Each cycle `wr_req`=1 && `wr_ack`=0 adds one cycle, with address held.
- `flush_busy` is high in DRAIN, WRITE and DONE; it stays continuously high across a back-to-back pending erase (DONE→DRAIN).
- `flush_done` is never high for two consecutive cycles.

## Test plan
- Reset, then pulse `table_flush` at cycle 10 with DEPTH=32, `lookup_idle`=1, `wr_ack`=1 → addresses 0..31 written, each once, from cycle 12 to 43, all data 0; `flush_done` at 44; `flush_busy` low at 45; `flush_count`=1.
- Hold `lookup_idle`=0 for 7 cycles after the strobe → no `wr_req` during DRAIN; first write is 7 cycles later than in the baseline; `flush_busy` high throughout.
- Random `wr_ack` backpressure (50%) → `wr_addr`/`wr_req` held stable while unacked; exactly 32 accepted writes in ascending order; single `flush_done`.
- Three `table_flush` strobes during WRITE plus one in DONE → exactly two erases total (64 writes); `flush_busy` never drops between them; `flush_count`=2.
- Assert `reset` at address 15 of an erase with a pending flag set → next cycle `wr_req`=0, `flush_busy`=0, `flush_count`=0; no further writes without a new strobe.
- DEPTH=5, ADDR_WIDTH=3, and preload `flush_count`=0xFFFF via 65535 erases (or force) → addresses 0..4 only, then `flush_count` wraps to 0x0000.
